maj_fold_accum: RTL and testbench

Folded, multi-cycle front end for the 39-input majority function. Accepts the 39-bit input vector as a stream of fixed-width chunks over a valid/ready handshake, accumulates the population count across beats, and emits a single majority decision (`y0`) plus the full count per vector. It sits directly upstream of the result consumer and replaces the flat 39-input combinational majority wherever input bandwidth is narrower than 39 bits.

---
 rtl/maj_fold_accum_pkg.sv | 21 ++
 rtl/maj_fold_accum_chunk_popcount.sv | 21 ++
 rtl/maj_fold_accum.sv | 94 +++++++++
 tb/tb_maj_fold_accum.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/maj_fold_accum_pkg.sv
// Shared constants and state type for the folded 39-input majority front end.
// Widths derive from N and CHUNK so the datapath resizes with them.
package maj_pkg;

    localparam int N         = 39;
    localparam int CHUNK     = 8;
    localparam int THRESH    = (N + 1) / 2;
    localparam int BEATS     = (N + CHUNK - 1) / CHUNK;
    localparam int CNT_W     = $clog2(N + 1);
    localparam int PC_W      = $clog2(CHUNK + 1);
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int LAST_BITS = N - (BEATS - 1) * CHUNK;

    localparam logic [CHUNK-1:0] LAST_MASK = CHUNK'((1 << LAST_BITS) - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/maj_fold_accum_chunk_popcount.sv
// Purpose: masked popcount of one input chunk; the last beat keeps only LAST_BITS.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module chunk_popcount
    import maj_pkg::*;
(
    input  logic [CHUNK-1:0] data,
    input  logic             last,
    output logic [PC_W-1:0]  cnt
);

    logic [CHUNK-1:0] masked;

    always_comb begin
        masked = last ? (data & LAST_MASK) : data;
        cnt    = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + PC_W'(masked[i]);
        end
    end

endmodule

// File: rtl/maj_fold_accum.sv
// Purpose: accumulates a 39-bit vector over 8-bit beats, emits majority and popcount.
// Latency: out_valid rises the cycle after the last-beat transfer; 6 cycles/vector min.
// Backpressure: result held in HOLD until out_ready; in_ready is low for that whole time.
module maj_fold_accum
    import maj_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y0,
    output logic [CNT_W-1:0] count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               y0_q, y0_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               last_beat;
    logic [PC_W-1:0]    chunk_cnt;
    logic [CNT_W-1:0]   sum;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    chunk_popcount u_chunk_popcount (
        .data (in_data),
        .last (last_beat),
        .cnt  (chunk_cnt)
    );

    assign sum = acc_q + CNT_W'(chunk_cnt);

    // Handshake outputs come straight from the state flop: no path from out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign y0        = y0_q;
    assign count     = count_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        y0_d    = y0_q;
        count_d = count_q;
        case (state_q)
            ACCUM: begin
                if (flush) begin
                    acc_d  = '0;
                    beat_d = '0;
                end else if (in_valid) begin
                    if (last_beat) begin
                        count_d = sum;
                        y0_d    = (sum >= CNT_W'(THRESH));
                        acc_d   = '0;
                        beat_d  = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d  = sum;
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            beat_q  <= '0;
            y0_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
            y0_q    <= y0_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_maj_fold_accum.sv
// Bench for maj_fold_accum: directed edge cases plus a randomized stream scored
// against a plain popcount-of-39-bits majority model.
module tb_maj_fold_accum;

    localparam int VN   = 39;
    localparam int VTH  = 20;
    localparam int NVEC = 10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic       y0;
    logic [5:0] count;

    int tests = 0;
    int fails = 0;

    maj_fold_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic drive_beat(input logic [7:0] d, input int gap);
        int b;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        b = 0;
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL beat_accept: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_vector(input logic [39:0] v, input bit gaps);
        for (int k = 0; k < 5; k++) begin
            drive_beat(v[k*8 +: 8], (gaps && $urandom_range(0, 7) == 0) ? 1 : 0);
        end
    endtask

    task automatic check_result(input logic [39:0] v, input int stall, input string name);
        int   ec;
        logic ey;
        int   b;
        logic [38:0] bits;
        bits = v[38:0];
        ec   = $countones(bits);
        ey   = (ec >= VTH);
        b = 0;
        while (!out_valid && b < 50) begin
            @(negedge clk);
            b++;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: out_valid=%b required 1", name, out_valid);
        end
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            tests++;
            if (count !== 6'(ec) || y0 !== ey || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL %s_stall%0d: count=%0d y0=%b in_ready=%b out_valid=%b required %0d %b 0 1",
                         name, s, count, y0, in_ready, out_valid, ec, ey);
            end
            @(negedge clk);
        end
        tests++;
        if (count !== 6'(ec) || y0 !== ey) begin
            fails++;
            $display("FAIL %s_result: count=%0d y0=%b required %0d %b", name, count, y0, ec, ey);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y0 !== 1'b0 || count !== 6'd0) begin
            fails++;
            $display("FAIL reset_during: in_ready=%b out_valid=%b y0=%b count=%0d required 1 0 0 0",
                     in_ready, out_valid, y0, count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y0 !== 1'b0 || count !== 6'd0) begin
            fails++;
            $display("FAIL reset_after: in_ready=%b out_valid=%b y0=%b count=%0d required 1 0 0 0",
                     in_ready, out_valid, y0, count);
        end
    endtask

    task automatic test_zero_latency();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL latency_early: out_valid=%b required 0", out_valid);
                end
            end
            drive_beat(8'h00, 0);
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency_cycle6: out_valid=%b required 1", out_valid);
        end
        check_result(40'h0, 0, "all_zero");
    endtask

    task automatic test_threshold();
        send_vector(40'h00_00_0F_FF_FF, 1'b0);
        check_result(40'h00_00_0F_FF_FF, 0, "thresh20");
        send_vector(40'h00_00_07_FF_FF, 1'b0);
        check_result(40'h00_00_07_FF_FF, 0, "thresh19");
    endtask

    task automatic test_mask();
        send_vector(40'hFF_FF_FF_FF_FF, 1'b0);
        check_result(40'hFF_FF_FF_FF_FF, 0, "mask39");
    endtask

    task automatic test_backpressure();
        send_vector(40'h12_34_56_78_9A, 1'b0);
        // Beats offered while the result is held must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        check_result(40'h12_34_56_78_9A, 3, "bp");
        in_valid = 1'b0;
        send_vector(40'h0, 1'b0);
        check_result(40'h0, 0, "bp_after");
    endtask

    task automatic test_reset_mid();
        drive_beat(8'hFF, 0);
        drive_beat(8'hFF, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_vector(40'h0, 1'b0);
        check_result(40'h0, 0, "rst_mid");
        send_vector(40'hFF_FF_FF_FF_FF, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || count !== 6'd0 || y0 !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_hold: out_valid=%b count=%0d y0=%b in_ready=%b required 0 0 0 1",
                     out_valid, count, y0, in_ready);
        end
    endtask

    task automatic test_flush();
        drive_beat(8'hFF, 0);
        drive_beat(8'hFF, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        send_vector(40'h0, 1'b0);
        check_result(40'h0, 0, "flush_mid");
        // Flush coinciding with a beat drops that beat.
        drive_beat(8'hFF, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        send_vector(40'h00_00_0F_FF_FF, 1'b0);
        check_result(40'h00_00_0F_FF_FF, 0, "flush_beat");
    endtask

    task automatic test_random();
        logic [39:0] v;
        int stall;
        for (int n = 0; n < NVEC; n++) begin
            v = {8'($urandom), 32'($urandom)};
            send_vector(v, 1'b1);
            stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
            check_result(v, stall, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_threshold();
        test_mask();
        test_backpressure();
        test_reset_mid();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
